sm_fetch: RTL and testbench

SM_FETCH -- requirements
Module: sm_fetch

---
 rtl/sm_fetch_if.sv | 21 ++
 rtl/sm_fetch.sv | 110 +++++++++++
 tb/tb_sm_fetch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the instruction queue head.
interface sm_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/sm_fetch.sv
// Instruction fetch unit: one outstanding memory request feeding a 2-entry {pc, instr} queue.
// Optional SM_FETCH_BYPASS_EN presents a returning word on the head in its ack cycle when the queue is empty.
module sm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    sm_fetch_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [63:0] fifo_q [2];
    logic [63:0] head;

    logic ack_live, bypass, pop, push, room, req;

    always_comb begin
        ack_live = (state_q == S_WAIT) && bus.mem_ack && !redirect;
        bypass   = 1'b0;
`ifdef SM_FETCH_BYPASS_EN
        bypass   = ack_live && (count_q == 2'd0);
`endif
        pop      = (count_q != 2'd0) && bus.instr_ready && !redirect;
        // A bypassed word taken in its ack cycle never enters the queue.
        push     = ack_live && !(bypass && bus.instr_ready);
        room     = (count_q != 2'd2) || pop;
        req      = rst_n && (state_q == S_IDLE) && !redirect && room;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.mem_ack)   state_d = S_IDLE;
                else if (redirect) state_d = S_DROP;
            end
            S_DROP: if (bus.mem_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head            = fifo_q[rd_ptr_q];
        bus.mem_req     = req;
        bus.mem_addr    = req ? fetch_pc_q : addr_q;
        bus.instr_valid = (count_q != 2'd0);
        bus.instr       = head[31:0];
        bus.instr_pc    = head[63:32];
`ifdef SM_FETCH_BYPASS_EN
        if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr       = bus.mem_rdata;
            bus.instr_pc    = fetch_pc_q;
        end
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            if (ack_live) fetch_pc_d = fetch_pc_q + 32'd1;
            if (push)     wr_ptr_d   = ~wr_ptr_q;
            if (pop)      rd_ptr_d   = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= 32'd0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= 64'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            // Hold the issued address so mem_addr stays put until the ack.
            if (req)  addr_q <= fetch_pc_q;
            if (push) fifo_q[wr_ptr_q] <= {fetch_pc_q, bus.mem_rdata};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));
endmodule

// File: tb/tb_sm_fetch.sv
// Randomized bench for sm_fetch: a queue-based model of the fetch stream plus a responding memory.
module tb_sm_fetch;
    localparam logic [31:0] RPC = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'd0;

    sm_fetch_if f();

    sm_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect),
        .redirect_addr(redirect_addr), .bus(f.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] mq[$];
    logic [31:0] seen[$];
    logic [31:0] fpc, out_addr, last_addr;
    bit outst, live, rdr_on_ack, last_rdr, last_req, last_v;
    int ack_cnt, lat_min, lat_max;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        fpc = RPC;
        outst = 1'b0;
        live = 1'b0;
        ack_cnt = 0;
    endtask

    task automatic tick(input bit rdr_in, input logic [31:0] raddr, input bit rdy, input bit spur);
        bit ack, rdr, byp, pop_m, exp_req, exp_v;
        logic [31:0] dat;
        logic [63:0] hd;
        int occ;
        @(negedge clk);
        ack = outst ? (ack_cnt == 0) : spur;
        rdr = rdr_in | (rdr_on_ack & outst & ack);
        dat = (outst && ack) ? mword(out_addr) : $urandom;
        redirect = rdr;
        redirect_addr = raddr;
        f.instr_ready = rdy;
        f.mem_ack = ack;
        f.mem_rdata = dat;
        #1;
        byp = 1'b0;
`ifdef SM_FETCH_BYPASS_EN
        byp = (mq.size() == 0) && outst && live && ack && !rdr;
`endif
        exp_v = (mq.size() != 0) || byp;
        chk("instr_valid", f.instr_valid, exp_v);
        if (mq.size() != 0) begin
            hd = mq[0];
            chk("instr", f.instr, hd[31:0]);
            chk("instr_pc", f.instr_pc, hd[63:32]);
        end else if (byp) begin
            chk("bypass_instr", f.instr, dat);
            chk("bypass_pc", f.instr_pc, out_addr);
        end
        pop_m = (mq.size() != 0) && rdy;
        occ = mq.size() - (pop_m ? 1 : 0);
        exp_req = !outst && !rdr && (occ < 2);
        chk("mem_req", f.mem_req, exp_req);
        if (exp_req) chk("mem_addr", f.mem_addr, fpc);
        if (f.instr_valid && rdy && !rdr) seen.push_back(f.instr_pc);
        last_rdr = rdr;
        last_req = f.mem_req;
        last_addr = f.mem_addr;
        last_v = f.instr_valid;
        @(posedge clk);
        if (outst && !ack && ack_cnt > 0) ack_cnt--;
        if (rdr) begin
            mq.delete();
            fpc = raddr;
            if (outst && ack) outst = 1'b0;
            else if (outst)   live = 1'b0;
        end else begin
            if (pop_m) void'(mq.pop_front());
            if (outst && ack) begin
                outst = 1'b0;
                if (live) begin
                    if (!(byp && rdy)) mq.push_back({fpc, dat});
                    fpc = fpc + 32'd1;
                end
            end else if (exp_req) begin
                outst = 1'b1;
                live = 1'b1;
                out_addr = fpc;
                ack_cnt = $urandom_range(lat_max, lat_min);
            end
        end
    endtask

    task automatic check_seq(input string tag, input logic [31:0] start, input int n);
        chk({tag, "_count"}, 32'(seen.size() >= n), 32'd1);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk({tag, "_pc"}, seen[i], start + 32'(i));
    endtask

    task automatic wait_outstanding(input string tag);
        int g = 0;
        while (!outst && g < 20) begin
            tick(1'b0, 32'd0, 1'b1, 1'b0);
            g++;
        end
        chk({tag, "_outstanding"}, 32'(outst), 32'd1);
    endtask

    initial begin
        int nreq;
        f.mem_ack = 1'b0;
        f.mem_rdata = 32'd0;
        f.instr_ready = 1'b0;
        rdr_on_ack = 1'b0;
        lat_min = 0;
        lat_max = 0;
        model_reset();

        // Reset values while rst_n is held low
        #1;
        chk("rst_mem_req", f.mem_req, 32'd0);
        chk("rst_valid", f.instr_valid, 32'd0);
        chk("rst_instr", f.instr, 32'd0);
        chk("rst_pc", f.instr_pc, 32'd0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

        // First request right after reset, then the wrap from 0xFFFF_FFFF
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        chk("first_req", 32'(last_req), 32'd1);
        chk("first_addr", last_addr, RPC);
        for (int i = 0; i < 12; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        check_seq("wrap", RPC, 3);

        // Redirect to 0, stream, stall 10 cycles, release
        seen.delete();
        tick(1'b1, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 32'd0, 1'b0, 1'b0);
            if (i >= 5 && last_req) nreq++;
        end
        chk("stall_req_stop", nreq, 32'd0);
        chk("stall_held", 32'(last_v), 32'd1);
        for (int i = 0; i < 20; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        check_seq("stream", 32'd0, 12);

        // Redirect to 0x40 while waiting, stale ack three cycles later
        lat_min = 3; lat_max = 3;
        wait_outstanding("drop");
        tick(1'b1, 32'h40, 1'b1, 1'b0);
        seen.delete();
        lat_min = 0; lat_max = 0;
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        chk("drop_flushed", 32'(last_v), 32'd0);
        for (int i = 0; i < 20; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        check_seq("drop", 32'h40, 3);

        // Redirect coinciding with mem_ack
        lat_min = 1; lat_max = 1;
        rdr_on_ack = 1'b1;
        begin
            int g = 0;
            last_rdr = 1'b0;
            while (!last_rdr && g < 20) begin
                tick(1'b0, 32'h200, 1'b1, 1'b0);
                g++;
            end
        end
        rdr_on_ack = 1'b0;
        chk("same_cycle_hit", 32'(last_rdr), 32'd1);
        tick(1'b0, 32'd0, 1'b1, 1'b0);
        chk("same_cycle_req", 32'(last_req), 32'd1);
        chk("same_cycle_addr", last_addr, 32'h200);

        // Reset while a request is outstanding, then a stray ack in IDLE
        lat_min = 3; lat_max = 3;
        wait_outstanding("midrst");
        @(negedge clk);
        #3 rst_n = 1'b0;
        f.mem_ack = 1'b0;
        redirect = 1'b0;
        #1;
        chk("midrst_req", f.mem_req, 32'd0);
        chk("midrst_valid", f.instr_valid, 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        lat_min = 0; lat_max = 0;
        seen.delete();
        tick(1'b0, 32'd0, 1'b1, 1'b1);
        chk("midrst_first_req", 32'(last_req), 32'd1);
        chk("midrst_first_addr", last_addr, RPC);
        for (int i = 0; i < 10; i++) tick(1'b0, 32'd0, 1'b1, 1'b0);
        check_seq("midrst", RPC, 2);

        // Random traffic
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFD + 32'($urandom_range(0, 2))) : $urandom;
            tick($urandom_range(0, 19) == 0, a, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
